// File: rtl/rgb_pwm_pkg.sv
// Shared constants, types and level-map helpers for the RGB PWM driver.
package rgb_pwm_pkg;

  localparam int FIELD_W      = 4;
  localparam int RED_LSB      = 0;
  localparam int GREEN_LSB    = 4;
  localparam int BLUE_LSB     = 8;
  localparam int DATA_W       = 12;
  localparam int LEVEL_W      = 8;
  localparam int CNT_W        = 4;
  localparam int PERIOD_STEPS = 255;

  typedef logic [FIELD_W-1:0] field_t;
  typedef logic [LEVEL_W-1:0] level_t;

  // Candidate word and how many consecutive boundaries have seen it.
  typedef struct packed {
    logic [DATA_W-1:0] cand;
    logic [CNT_W-1:0]  cnt;
  } filter_t;

  localparam level_t GAMMA_LUT [16] = '{
    8'd0,  8'd1,  8'd2,  8'd4,   8'd7,   8'd11,  8'd17,  8'd25,
    8'd35, 8'd48, 8'd64, 8'd83,  8'd106, 8'd134, 8'd167, 8'd255
  };

  function automatic level_t linear_level(input field_t n);
    return level_t'(n) * 8'd17;
  endfunction

  function automatic level_t gamma_level(input field_t n);
    return GAMMA_LUT[n];
  endfunction

endpackage

// File: rtl/rgb_pwm_if.sv
// Board-side bundle of the RGB PWM block: key-scanner word in, PWM drive out.
interface rgb_pwm_if;
  import rgb_pwm_pkg::*;

  logic [DATA_W-1:0] data;
  logic              pwm_r;
  logic              pwm_g;
  logic              pwm_b;
  logic              period_start;
  logic [DATA_W-1:0] active_data;

  modport master (
    output data,
    input  pwm_r, pwm_g, pwm_b, period_start, active_data
  );

  modport slave (
    input  data,
    output pwm_r, pwm_g, pwm_b, period_start, active_data
  );

endinterface

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: 4-bit field -> 8-bit level, compare against phase, register.
// Define RGB_PWM_GAMMA_EN to use the gamma table instead of the linear n*17 map.
module pwm_channel
  import rgb_pwm_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  field_t field,
  input  level_t phase,
  output logic   pwm
);

  level_t level;

  always_comb begin
`ifdef RGB_PWM_GAMMA_EN
    level = gamma_level(field);
`else
    level = linear_level(field);
`endif
  end

  // Phase never exceeds 254, so level 255 keeps the output high across boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm <= 1'b0;
    else        pwm <= (phase < level);
  end

endmodule

// File: rtl/rgb_pwm.sv
// RGB PWM driver: prescaler, 255-step phase counter, boundary stability filter,
// and three pwm_channel instances driven by the committed duty word.
module rgb_pwm
  import rgb_pwm_pkg::*;
#(
  parameter int PRESCALE       = 4,
  parameter int STABLE_PERIODS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  output logic              pwm_r,
  output logic              pwm_g,
  output logic              pwm_b,
  output logic              period_start,
  output logic [DATA_W-1:0] active_data
);

  localparam int               PRE_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(PRESCALE - 1);
  localparam level_t           PHASE_LAST = level_t'(PERIOD_STEPS - 1);
  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_PERIODS);

  logic [PRE_W-1:0]  presc;
  level_t            phase;
  logic              boundary;
  filter_t           filt;
  filter_t           filt_nxt;
  logic [DATA_W-1:0] active_nxt;

  // Counters hold the position of the clock about to be registered, so the
  // first edge after reset is itself a period boundary.
  assign boundary = (presc == '0) && (phase == '0);

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    filt_nxt   = filt;
    active_nxt = active_data;
    if (boundary) begin
      if (data == filt.cand) begin
        if (filt.cnt != '1) filt_nxt.cnt = filt.cnt + CNT_W'(1);
      end else begin
        filt_nxt.cand = data;
        filt_nxt.cnt  = CNT_W'(1);
      end
      // Commit feeds the channels combinationally so the new duty applies
      // to the period that starts at this very boundary.
      if (filt_nxt.cnt == STABLE_CNT) active_nxt = filt_nxt.cand;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      phase        <= '0;
      filt         <= '0;
      active_data  <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      filt         <= filt_nxt;
      active_data  <= active_nxt;
      if (presc == PRE_LAST) begin
        presc <= '0;
        phase <= (phase == PHASE_LAST) ? '0 : phase + 8'd1;
      end else begin
        presc <= presc + PRE_W'(1);
      end
    end
  end

  pwm_channel u_red (
    .clk   (clk),
    .rst_n (rst_n),
    .field (active_nxt[RED_LSB +: FIELD_W]),
    .phase (phase),
    .pwm   (pwm_r)
  );

  pwm_channel u_green (
    .clk   (clk),
    .rst_n (rst_n),
    .field (active_nxt[GREEN_LSB +: FIELD_W]),
    .phase (phase),
    .pwm   (pwm_g)
  );

  pwm_channel u_blue (
    .clk   (clk),
    .rst_n (rst_n),
    .field (active_nxt[BLUE_LSB +: FIELD_W]),
    .phase (phase),
    .pwm   (pwm_b)
  );

endmodule

// File: tb/tb_rgb_pwm.sv
// Self-checking bench for rgb_pwm (PRESCALE=2, STABLE_PERIODS=2); honours RGB_PWM_GAMMA_EN.
module tb_rgb_pwm;

  localparam int P           = 2;
  localparam int STABLE      = 2;
  localparam int PERIOD_CLKS = 255 * P;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rgb_pwm_if bus ();

  rgb_pwm #(.PRESCALE(P), .STABLE_PERIODS(STABLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (bus.data),
    .pwm_r        (bus.pwm_r),
    .pwm_g        (bus.pwm_g),
    .pwm_b        (bus.pwm_b),
    .period_start (bus.period_start),
    .active_data  (bus.active_data)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int gamma_tab [16] = '{0, 1, 2, 4, 7, 11, 17, 25, 35, 48, 64, 83, 106, 134, 167, 255};

  // Reference model: history of boundary samples since reset.
  logic [11:0] hist [$];
  logic [11:0] exp_act = '0;

  function automatic int ref_level(input logic [3:0] n);
`ifdef RGB_PWM_GAMMA_EN
    return gamma_tab[n];
`else
    return int'(n) * 17;
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_act = '0;
  endtask

  // Commit when the run of identical trailing samples reaches STABLE.
  task automatic model_boundary(input logic [11:0] sample);
    int run = 0;
    hist.push_back(sample);
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != sample) break;
      run++;
    end
    if (run == STABLE) exp_act = sample;
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Drives one period starting at the next edge (a boundary) and checks it clock by clock.
  task automatic run_period(input logic [11:0] sample, input bit jitter, input int n_clks,
                            output int hi_r, output int hi_g, output int hi_b,
                            output logic [11:0] act);
    int lr, lg, lb;
    int bad_r = 0, bad_g = 0, bad_b = 0, bad_ps = 0, bad_act = 0;
    model_boundary(sample);
    lr = ref_level(exp_act[3:0]);
    lg = ref_level(exp_act[7:4]);
    lb = ref_level(exp_act[11:8]);
    bus.data = sample;
    hi_r = 0; hi_g = 0; hi_b = 0; act = '0;
    for (int i = 0; i < n_clks; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) act = bus.active_data;
      if (bus.pwm_r === 1'b1) hi_r++;
      if (bus.pwm_g === 1'b1) hi_g++;
      if (bus.pwm_b === 1'b1) hi_b++;
      if (bus.pwm_r !== (i < lr * P)) bad_r++;
      if (bus.pwm_g !== (i < lg * P)) bad_g++;
      if (bus.pwm_b !== (i < lb * P)) bad_b++;
      if (bus.period_start !== (i == 0)) bad_ps++;
      if (bus.active_data !== exp_act) bad_act++;
      if (jitter) bus.data = 12'($urandom);
    end
    check("pwm_r bad clocks", bad_r, 0);
    check("pwm_g bad clocks", bad_g, 0);
    check("pwm_b bad clocks", bad_b, 0);
    check("period_start bad clocks", bad_ps, 0);
    check("active_data bad clocks", bad_act, 0);
    if (n_clks == PERIOD_CLKS) begin
      check("pwm_r high clocks", hi_r, lr * P);
      check("pwm_g high clocks", hi_g, lg * P);
      check("pwm_b high clocks", hi_b, lb * P);
    end
  endtask

  typedef struct {
    logic [11:0] data;
    int          periods;
    logic [11:0] exp_act;
    int          hi_r;
    int          hi_g;
    int          hi_b;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int hr, hg, hb;
    logic [11:0] act;
    logic [11:0] s;

`ifdef RGB_PWM_GAMMA_EN
    tbl[0] = '{12'h00F, 2, 12'h00F, 510, 0,   0};
    tbl[1] = '{12'h8A1, 2, 12'h8A1, 2,   128, 70};
    tbl[2] = '{12'h000, 2, 12'h000, 0,   0,   0};
    tbl[3] = '{12'hFFF, 2, 12'hFFF, 510, 510, 510};
    tbl[4] = '{12'h005, 2, 12'h005, 22,  0,   0};
`else
    tbl[0] = '{12'h00F, 2, 12'h00F, 510, 0,   0};
    tbl[1] = '{12'h8A1, 2, 12'h8A1, 34,  340, 272};
    tbl[2] = '{12'h000, 2, 12'h000, 0,   0,   0};
    tbl[3] = '{12'hFFF, 2, 12'hFFF, 510, 510, 510};
    tbl[4] = '{12'h005, 2, 12'h005, 170, 0,   0};
`endif

    // Reset held across several edges: everything stays cleared.
    bus.data = 12'h0;
    repeat (3) @(negedge clk);
    check("reset pwm_r", bus.pwm_r, 0);
    check("reset pwm_g", bus.pwm_g, 0);
    check("reset pwm_b", bus.pwm_b, 0);
    check("reset period_start", bus.period_start, 0);
    check("reset active_data", bus.active_data, 0);
    rst_n = 1'b1;
    model_reset();

    // Idle period right after reset: outputs constant 0, period_start on first clock.
    run_period(12'h000, 0, PERIOD_CLKS, hr, hg, hb, act);

    // Table: each word held for its periods with jitter inside each period.
    for (int v = 0; v < 5; v++) begin
      for (int p = 0; p < tbl[v].periods; p++)
        run_period(tbl[v].data, 1'b1, PERIOD_CLKS, hr, hg, hb, act);
      check("table active_data", act, tbl[v].exp_act);
      check("table r high", hr, tbl[v].hi_r);
      check("table g high", hg, tbl[v].hi_g);
      check("table b high", hb, tbl[v].hi_b);
    end

    // Alternating samples never qualify, so the last committed word stays.
    for (int k = 0; k < 6; k++) begin
      run_period((k % 2) ? 12'h456 : 12'h123, 1'b0, PERIOD_CLKS, hr, hg, hb, act);
      check("toggle holds active_data", act, tbl[4].exp_act);
    end

    // Random words, usually repeated so commits happen, with jitter inside periods.
    s = 12'($urandom);
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 2) == 0) s = 12'($urandom);
      run_period(s, 1'b1, PERIOD_CLKS, hr, hg, hb, act);
    end

    // Mid-period reset at phase 100 with FFF committed.
    run_period(12'hFFF, 1'b0, PERIOD_CLKS, hr, hg, hb, act);
    run_period(12'hFFF, 1'b0, PERIOD_CLKS, hr, hg, hb, act);
    check("pre-reset committed", act, 12'hFFF);
    run_period(12'hFFF, 1'b0, 201, hr, hg, hb, act);
    check("pwm_r high before reset", bus.pwm_r, 1);
    rst_n = 1'b0;
    #1;
    check("mid reset pwm_r", bus.pwm_r, 0);
    check("mid reset pwm_g", bus.pwm_g, 0);
    check("mid reset pwm_b", bus.pwm_b, 0);
    check("mid reset period_start", bus.period_start, 0);
    check("mid reset active_data", bus.active_data, 0);
    #4;
    rst_n = 1'b1;
    model_reset();
    run_period(12'hFFF, 1'b0, PERIOD_CLKS, hr, hg, hb, act);
    check("recommit first boundary", act, 12'h000);
    run_period(12'hFFF, 1'b0, PERIOD_CLKS, hr, hg, hb, act);
    check("recommit second boundary", act, 12'hFFF);
    run_period(12'hFFF, 1'b0, 4, hr, hg, hb, act);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
